// File: rtl/calc_pkg.sv
// Shared definitions for the calculator core: key codes, FSM states,
// operator encoding and small key-decode helpers.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_MUL = 4'd11;
  localparam logic [3:0] KEY_SUB = 4'd12;
  localparam logic [3:0] KEY_ENT = 4'd13;
  localparam logic [3:0] KEY_BS  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [2:0] {
    ST_ENT_A = 3'd0,
    ST_ENT_B = 3'd1,
    ST_CALC  = 3'd2,
    ST_CONV  = 3'd3,
    ST_SHOW  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MUL = 2'd1,
    OP_SUB = 2'd2
  } op_t;

  function automatic logic is_digit_key(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op_key(input logic [3:0] k);
    return (k == KEY_ADD) || (k == KEY_MUL) || (k == KEY_SUB);
  endfunction

  function automatic op_t key_to_op(input logic [3:0] k);
    case (k)
      KEY_MUL: return OP_MUL;
      KEY_SUB: return OP_SUB;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_if.sv
// Key-in / display-out bundle between the key decoder, the calculator core
// and the display driver.
interface calc_if #(
  parameter int N_DIGITS = 2
) ();

  logic                    key_valid;
  logic [3:0]              key_code;
  logic [8*N_DIGITS-1:0]   disp_bcd;
  logic                    neg;
  logic                    busy;
  logic                    done;
  logic [2:0]              state;

  modport master (
    output key_valid, key_code,
    input  disp_bcd, neg, busy, done, state
  );

  modport slave (
    input  key_valid, key_code,
    output disp_bcd, neg, busy, done, state
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: RW steps, one bit per cycle.
// The start cycle already performs the first step (the BCD accumulator is
// zero then, so its add-3 pass is a no-op), and done pulses together with
// the last step, so bcd is valid while done is high.
module bin2bcd_seq #(
  parameter int RW = 14,
  parameter int ND = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  logic [RW-1:0]   bin,
  output logic [4*ND-1:0] bcd,
  output logic            done
);

  localparam int CW = $clog2(RW + 1);
  localparam int SW = 4*ND + RW;

  logic [RW-1:0] bin_sh;
  logic [CW-1:0] cnt;
  logic [SW-1:0] step_in;
  logic [SW-1:0] step_out;

  function automatic logic [SW-1:0] dabble(input logic [SW-1:0] v);
    logic [SW-1:0] t;
    t = v;
    for (int i = 0; i < ND; i++) begin
      if (t[RW+4*i +: 4] >= 4'd5)
        t[RW+4*i +: 4] = t[RW+4*i +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  assign step_in  = start ? {{(4*ND){1'b0}}, bin} : {bcd, bin_sh};
  assign step_out = dabble(step_in);

  // Step counter and done pulse; abort (clear key) kills a conversion.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cnt <= CW'(RW - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1))
          done <= 1'b1;
      end
    end
  end

  // Shift/add-3 datapath, advanced on every active conversion cycle.
  always_ff @(posedge clk) begin
    if (start || cnt != '0)
      {bcd, bin_sh} <= step_out;
  end

endmodule

// File: rtl/calc_core.sv
// Calculator core: collects operand A, operator and operand B from key
// codes, computes add/sub in one cycle or multiply by shift-add, converts
// the binary result to BCD sequentially and drives the digit display.
module calc_core
  import calc_pkg::*;
#(
  parameter int N_DIGITS = 2
) (
  input  logic clk,
  input  logic rst_n,
  calc_if.slave bus
);

  localparam int AW = $clog2(10**N_DIGITS);
  localparam int RW = 2*AW;
  localparam int ND = 2*N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int MW = $clog2(AW);
  localparam logic [RW-1:0] CHAIN_LIM = RW'(10**N_DIGITS);

  state_t          st;
  op_t             op;
  logic [AW-1:0]   a;
  logic [AW-1:0]   b;
  logic [CW-1:0]   cnt_a;
  logic [CW-1:0]   cnt_b;
  logic [RW-1:0]   result;
  logic [RW-1:0]   mcand;
  logic [AW-1:0]   mplier;
  logic [MW-1:0]   mstep;
  logic            conv_start;
  logic            neg_q;
  logic            busy_q;
  logic            done_q;
  logic [4*ND-1:0] show_disp;
  logic [4*ND-1:0] conv_bcd;
  logic            conv_done;
  logic            clr_key;

  // Append one decimal digit; callers guarantee the result fits AW bits.
  function automatic logic [AW-1:0] push_digit(input logic [AW-1:0] v,
                                               input logic [3:0]    d);
    return AW'(({4'd0, v} * (AW+4)'(10)) + (AW+4)'(d));
  endfunction

  function automatic logic [AW-1:0] drop_digit(input logic [AW-1:0] v);
    return v / AW'(10);
  endfunction

  // Number of significant decimal digits of a value below 10**N_DIGITS
  // (zero counts as one digit).
  function automatic logic [CW-1:0] sig_digits(input logic [RW-1:0] r);
    logic [CW-1:0] c;
    c = CW'(1);
    for (int k = 1; k < N_DIGITS; k++) begin
      if (r >= RW'(10**k))
        c = CW'(k + 1);
    end
    return c;
  endfunction

  // Combinational double-dabble for the operand shown during entry.
  function automatic logic [4*N_DIGITS-1:0] opnd_bcd(input logic [AW-1:0] v);
    logic [4*N_DIGITS+AW-1:0] t;
    t = {{(4*N_DIGITS){1'b0}}, v};
    for (int s = 0; s < AW; s++) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (t[AW+4*i +: 4] >= 4'd5)
          t[AW+4*i +: 4] = t[AW+4*i +: 4] + 4'd3;
      end
      t = t << 1;
    end
    return t[AW +: 4*N_DIGITS];
  endfunction

  // Right-aligned operand: only the typed digit positions are lit, and an
  // empty operand still shows a single 0.
  function automatic logic [4*ND-1:0] opnd_disp(input logic [AW-1:0] v,
                                                input logic [CW-1:0] c);
    logic [4*N_DIGITS-1:0] dig;
    logic [4*ND-1:0]       r;
    dig = opnd_bcd(v);
    r   = {ND{BLANK}};
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i == 0 || i < int'(c))
        r[4*i +: 4] = dig[4*i +: 4];
    end
    return r;
  endfunction

  // Blank leading zeros of the result, always keeping the last digit.
  function automatic logic [4*ND-1:0] blank_lead(input logic [4*ND-1:0] d);
    logic [4*ND-1:0] r;
    logic            lead;
    r    = d;
    lead = 1'b1;
    for (int i = ND - 1; i >= 1; i--) begin
      if (lead && d[4*i +: 4] == 4'd0)
        r[4*i +: 4] = BLANK;
      else
        lead = 1'b0;
    end
    return r;
  endfunction

  assign clr_key = bus.key_valid && (bus.key_code == KEY_CLR);

  bin2bcd_seq #(
    .RW (RW),
    .ND (ND)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (clr_key),
    .start (conv_start),
    .bin   (result),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // Main FSM: key entry, arithmetic, conversion hand-off and result display.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_key) begin
      st         <= ST_ENT_A;
      op         <= OP_ADD;
      a          <= '0;
      b          <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      result     <= '0;
      mstep      <= '0;
      conv_start <= 1'b0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      conv_start <= 1'b0;
      case (st)
        ST_ENT_A: begin
          if (bus.key_valid) begin
            if (is_digit_key(bus.key_code)) begin
              if (cnt_a != CW'(N_DIGITS)) begin
                a     <= push_digit(a, bus.key_code);
                cnt_a <= cnt_a + CW'(1);
              end
            end else if (bus.key_code == KEY_BS) begin
              if (cnt_a != '0) begin
                a     <= drop_digit(a);
                cnt_a <= cnt_a - CW'(1);
              end
            end else if (is_op_key(bus.key_code)) begin
              op    <= key_to_op(bus.key_code);
              b     <= '0;
              cnt_b <= '0;
              st    <= ST_ENT_B;
            end
          end
        end
        ST_ENT_B: begin
          if (bus.key_valid) begin
            if (is_digit_key(bus.key_code)) begin
              if (cnt_b != CW'(N_DIGITS)) begin
                b     <= push_digit(b, bus.key_code);
                cnt_b <= cnt_b + CW'(1);
              end
            end else if (bus.key_code == KEY_BS) begin
              if (cnt_b != '0) begin
                b     <= drop_digit(b);
                cnt_b <= cnt_b - CW'(1);
              end
            end else if (is_op_key(bus.key_code)) begin
              op <= key_to_op(bus.key_code);
            end else if (bus.key_code == KEY_ENT) begin
              result <= '0;
              mcand  <= RW'(a);
              mplier <= b;
              mstep  <= '0;
              busy_q <= 1'b1;
              st     <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          case (op)
            OP_SUB: begin
              if (a >= b) begin
                result <= RW'(a - b);
                neg_q  <= 1'b0;
              end else begin
                result <= RW'(b - a);
                neg_q  <= 1'b1;
              end
              conv_start <= 1'b1;
              st         <= ST_CONV;
            end
            OP_MUL: begin
              if (mplier[0])
                result <= result + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
              mstep  <= mstep + MW'(1);
              if (mstep == MW'(AW - 1)) begin
                conv_start <= 1'b1;
                st         <= ST_CONV;
              end
            end
            default: begin
              result     <= RW'(a) + RW'(b);
              neg_q      <= 1'b0;
              conv_start <= 1'b1;
              st         <= ST_CONV;
            end
          endcase
        end
        ST_CONV: begin
          if (conv_done) begin
            show_disp <= blank_lead(conv_bcd);
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            st        <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (bus.key_valid) begin
            if (is_digit_key(bus.key_code)) begin
              a     <= AW'(bus.key_code);
              cnt_a <= CW'(1);
              neg_q <= 1'b0;
              st    <= ST_ENT_A;
            end else if (is_op_key(bus.key_code) && !neg_q &&
                         result < CHAIN_LIM) begin
              a     <= AW'(result);
              cnt_a <= sig_digits(result);
              op    <= key_to_op(bus.key_code);
              b     <= '0;
              cnt_b <= '0;
              st    <= ST_ENT_B;
            end
          end
        end
        default: st <= ST_ENT_A;
      endcase
    end
  end

  // Display source: live operand during entry, B held through CALC/CONV,
  // latched converted result in SHOW.
  always_comb begin
    bus.disp_bcd = opnd_disp(b, cnt_b);
    if (st == ST_SHOW)
      bus.disp_bcd = show_disp;
    else if (st == ST_ENT_A)
      bus.disp_bcd = opnd_disp(a, cnt_a);
  end

  assign bus.neg   = neg_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = st;

endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core with N_DIGITS=2 (AW=7, RW=14).
module tb_calc_core;

  localparam int LAT_ADD = 16;  // 1 + RW + 1
  localparam int LAT_MUL = 22;  // AW + RW + 1

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   lat;
  int   w;
  logic done_seen;

  calc_if #(.N_DIGITS(2)) bus ();

  calc_core #(.N_DIGITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic enter_timed(output int l);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd13;
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk("calc_state", 32'(bus.state), 32'd2);
    chk("calc_busy", 32'(bus.busy), 32'd1);
    l = 0;
    while (!bus.done && l < 200) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_neg", 32'(bus.neg), 32'd0);
    chk("rst_disp", 32'(bus.disp_bcd), 32'hFFF0);

    // 12 + 34
    press(4'd1); press(4'd2);
    chk("ent_a_12", 32'(bus.disp_bcd), 32'hFF12);
    press(4'd10);
    chk("op_state", 32'(bus.state), 32'd1);
    chk("ent_b_empty", 32'(bus.disp_bcd), 32'hFFF0);
    press(4'd3); press(4'd4);
    chk("ent_b_34", 32'(bus.disp_bcd), 32'hFF34);
    enter_timed(lat);
    chk("lat_add", 32'(lat), 32'(LAT_ADD));
    chk("add_state", 32'(bus.state), 32'd4);
    chk("add_disp", 32'(bus.disp_bcd), 32'hFF46);
    chk("add_neg", 32'(bus.neg), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("show_busy", 32'(bus.busy), 32'd0);

    // chain: 46 + 4
    press(4'd10);
    chk("chain_state", 32'(bus.state), 32'd1);
    press(4'd4);
    enter_timed(lat);
    chk("chain_lat", 32'(lat), 32'(LAT_ADD));
    chk("chain_disp", 32'(bus.disp_bcd), 32'hFF50);

    // 7 - 25 = -18
    press(4'd7);
    chk("new_a_state", 32'(bus.state), 32'd0);
    chk("new_a_disp", 32'(bus.disp_bcd), 32'hFFF7);
    press(4'd12); press(4'd2); press(4'd5);
    enter_timed(lat);
    chk("sub_lat", 32'(lat), 32'(LAT_ADD));
    chk("sub_disp", 32'(bus.disp_bcd), 32'hFF18);
    chk("sub_neg", 32'(bus.neg), 32'd1);
    press(4'd10);
    chk("chain_neg_ign", 32'(bus.state), 32'd4);

    // 99 * 99 = 9801
    press(4'd9);
    chk("mul_neg_clr", 32'(bus.neg), 32'd0);
    press(4'd9); press(4'd11); press(4'd9); press(4'd9);
    enter_timed(lat);
    chk("mul_lat", 32'(lat), 32'(LAT_MUL));
    chk("mul_disp", 32'(bus.disp_bcd), 32'h9801);
    chk("mul_neg", 32'(bus.neg), 32'd0);
    press(4'd10);
    chk("chain_big_ign", 32'(bus.state), 32'd4);
    chk("chain_big_disp", 32'(bus.disp_bcd), 32'h9801);

    // entry limit and backspace
    press(4'd15);
    chk("clr_state", 32'(bus.state), 32'd0);
    chk("clr_disp", 32'(bus.disp_bcd), 32'hFFF0);
    press(4'd1); press(4'd2); press(4'd3);
    chk("limit_disp", 32'(bus.disp_bcd), 32'hFF12);
    press(4'd14);
    chk("bs1_disp", 32'(bus.disp_bcd), 32'hFFF1);
    press(4'd14); press(4'd14);
    chk("bs3_disp", 32'(bus.disp_bcd), 32'hFFF0);
    press(4'd5);
    chk("after_bs_disp", 32'(bus.disp_bcd), 32'hFFF5);

    // clear in the third CONV cycle
    press(4'd15);
    press(4'd9); press(4'd9); press(4'd11); press(4'd9); press(4'd9);
    press(4'd13);
    w = 0;
    while (bus.state != 3'd3 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("reach_conv", 32'(bus.state), 32'd3);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd15;
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk("conv_clr_state", 32'(bus.state), 32'd0);
    chk("conv_clr_busy", 32'(bus.busy), 32'd0);
    chk("conv_clr_disp", 32'(bus.disp_bcd), 32'hFFF0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_seen = 1'b1;
      @(negedge clk);
    end
    chk("conv_clr_nodone", 32'(done_seen), 32'd0);

    // reset during CALC of a multiply
    press(4'd9); press(4'd9); press(4'd11); press(4'd9); press(4'd9);
    press(4'd13);
    chk("mid_calc_state", 32'(bus.state), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_state", 32'(bus.state), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_neg", 32'(bus.neg), 32'd0);
    chk("mid_rst_disp", 32'(bus.disp_bcd), 32'hFFF0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
